// File: rtl/decoder_minterm_scanner.sv
// Registered active-low N-to-2^N decoder with 138-style enables, a sum-of-minterms output
// and a self-test scan that captures the truth table. Optional mismatch counter: SCAN_MISMATCH_CNT_EN.
module decoder_minterm_scanner #(
   parameter int unsigned SEL_W = 3,
   parameter logic [(1<<SEL_W)-1:0] MINTERMS = 8'b1010_0101,
   parameter int unsigned STEP_DIV = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      g1,
   input  logic                      g2a_n,
   input  logic                      g2b_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel_in,
   input  logic                      start,
   output logic [(1<<SEL_W)-1:0]     y_n,
   output logic                      f_out,
   output logic [SEL_W-1:0]          cur_sel,
   output logic                      busy,
   output logic                      done,
   output logic [(1<<SEL_W)-1:0]     tt,
`ifdef SCAN_MISMATCH_CNT_EN
   output logic [SEL_W:0]            mismatch_cnt,
`endif
   output logic                      match
);

   localparam int unsigned NUM_CODES = 1 << SEL_W;
   localparam int unsigned STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned MM_W      = SEL_W + 1;
   localparam logic [NUM_CODES-1:0] ONE      = NUM_CODES'(1);
   localparam logic [SEL_W-1:0]     LAST_SEL = {SEL_W{1'b1}};
   localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(STEP_DIV - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]           state, state_nxt;
   logic [STEP_W-1:0]    step_cnt, step_nxt;
   logic [SEL_W-1:0]     cur_sel_nxt;
   logic [NUM_CODES-1:0] y_n_nxt, tt_nxt;
   logic                 f_nxt, busy_nxt, done_nxt, match_nxt;

   logic en_c, capture_c, cap_bit_c, scan_start_c;

   assign en_c         = g1 & ~g2a_n & ~g2b_n;
   assign capture_c    = en_c & (step_cnt == LAST_STEP);
   assign scan_start_c = (state == IDLE) & mode & start;
   // function value of the code currently on the outputs
   assign cap_bit_c    = |((ONE << cur_sel) & MINTERMS);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state and next-output logic
   always_comb begin
      state_nxt   = state;
      step_nxt    = step_cnt;
      cur_sel_nxt = cur_sel;
      tt_nxt      = tt;
      match_nxt   = match;
      busy_nxt    = 1'b0;
      done_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (scan_start_c) begin
               state_nxt   = SCAN;
               cur_sel_nxt = '0;
               step_nxt    = '0;
               tt_nxt      = '0;
               match_nxt   = 1'b0;
               busy_nxt    = 1'b1;
            end else if (!mode) begin
               cur_sel_nxt = sel_in;
            end
         end
         SCAN: begin
            busy_nxt = 1'b1;
            if (capture_c) begin
               tt_nxt[cur_sel] = cap_bit_c;
               step_nxt        = '0;
               if (cur_sel == LAST_SEL) begin
                  // match is resolved here so it is already valid while done is high
                  state_nxt   = DONE;
                  cur_sel_nxt = '0;
                  busy_nxt    = 1'b0;
                  done_nxt    = 1'b1;
                  match_nxt   = (tt_nxt == MINTERMS);
               end else begin
                  cur_sel_nxt = cur_sel + 1'b1;
               end
            end else if (en_c) begin
               step_nxt = step_cnt + 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      y_n_nxt = en_c ? ~(ONE << cur_sel_nxt) : '1;
      f_nxt   = |(~y_n_nxt & MINTERMS);
   end

   // registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_cnt <= '0;
         cur_sel  <= '0;
         y_n      <= '1;
         f_out    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tt       <= '0;
         match    <= 1'b0;
      end else begin
         step_cnt <= step_nxt;
         cur_sel  <= cur_sel_nxt;
         y_n      <= y_n_nxt;
         f_out    <= f_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         tt       <= tt_nxt;
         match    <= match_nxt;
      end
   end

`ifdef SCAN_MISMATCH_CNT_EN
   logic [MM_W-1:0] mm_nxt;

   // saturating count of captured bits that disagree with the expected mask
   always_comb begin
      mm_nxt = mismatch_cnt;
      if (scan_start_c) begin
         mm_nxt = '0;
      end else if ((state == SCAN) && capture_c && (cap_bit_c != MINTERMS[cur_sel]) &&
                   (mismatch_cnt != MM_W'(NUM_CODES))) begin
         mm_nxt = mismatch_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mismatch_cnt <= '0;
      else        mismatch_cnt <= mm_nxt;
   end
`endif

endmodule

// File: tb/tb_decoder_minterm_scanner.sv
// Bench for decoder_minterm_scanner: two instances (mask A5/step 1 and mask A4/step 2),
// random direct decode and scans checked against an arithmetic reference model.
module tb_decoder_minterm_scanner;

   logic       clk;
   logic       rst_n;
   logic       g1, g2a_n, g2b_n, mode, start;
   logic [2:0] sel_in;

   logic [7:0] y_n1, tt1, y_n2, tt2;
   logic [2:0] cur_sel1, cur_sel2;
   logic       f_out1, busy1, done1, match1;
   logic       f_out2, busy2, done2, match2;
`ifdef SCAN_MISMATCH_CNT_EN
   logic [3:0] mm1, mm2;
`endif

   logic [7:0] m1 = 8'hA5;
   logic [7:0] m2 = 8'hA4;

   int errors = 0;
   int checks = 0;

   decoder_minterm_scanner #(.SEL_W(3), .MINTERMS(8'hA5), .STEP_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
      .mode(mode), .sel_in(sel_in), .start(start),
      .y_n(y_n1), .f_out(f_out1), .cur_sel(cur_sel1), .busy(busy1), .done(done1), .tt(tt1),
`ifdef SCAN_MISMATCH_CNT_EN
      .mismatch_cnt(mm1),
`endif
      .match(match1));

   decoder_minterm_scanner #(.SEL_W(3), .MINTERMS(8'hA4), .STEP_DIV(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
      .mode(mode), .sel_in(sel_in), .start(start),
      .y_n(y_n2), .f_out(f_out2), .cur_sel(cur_sel2), .busy(busy2), .done(done2), .tt(tt2),
`ifdef SCAN_MISMATCH_CNT_EN
      .mismatch_cnt(mm2),
`endif
      .match(match2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scan on dut1; enable drops either random or a fixed window. Model: the scan position
   // equals the number of enabled cycles seen so far, and the truth table equals the mask.
   task automatic scan_dut1(input string tag, input int drop_at, input int drop_len, input bit rnd);
      int         en_cnt;
      int         cyc;
      bit         en;
      logic [7:0] exp_y;
      g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
      mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("%s_first_sel", tag), cur_sel1, 0);
      chk($sformatf("%s_first_y", tag), y_n1, 8'hFE);
      chk($sformatf("%s_first_tt", tag), tt1, 0);
      en_cnt = 0;
      cyc = 0;
      while (en_cnt < 8 && cyc < 200) begin
         if (rnd) en = ($urandom_range(3) != 0);
         else     en = !(cyc >= drop_at && cyc < drop_at + drop_len);
         g1 = en;
         tick();
         cyc++;
         if (en) en_cnt++;
         if (en_cnt < 8) begin
            exp_y = en ? ~(8'd1 << en_cnt) : 8'hFF;
            chk($sformatf("%s_busy_c%0d", tag, cyc), busy1, 1);
            chk($sformatf("%s_done_c%0d", tag, cyc), done1, 0);
            chk($sformatf("%s_sel_c%0d", tag, cyc), cur_sel1, en_cnt);
            chk($sformatf("%s_y_c%0d", tag, cyc), y_n1, exp_y);
            chk($sformatf("%s_f_c%0d", tag, cyc), f_out1, en && m1[en_cnt]);
         end
      end
      chk($sformatf("%s_done", tag), done1, 1);
      chk($sformatf("%s_busy_end", tag), busy1, 0);
      chk($sformatf("%s_sel_wrap", tag), cur_sel1, 0);
      chk($sformatf("%s_tt", tag), tt1, m1);
      chk($sformatf("%s_match", tag), match1, 1);
`ifdef SCAN_MISMATCH_CNT_EN
      chk($sformatf("%s_mm", tag), mm1, 0);
`endif
      g1 = 1'b1;
      tick();
      chk($sformatf("%s_done_pulse", tag), done1, 0);
      chk($sformatf("%s_tt_hold", tag), tt1, m1);
      chk($sformatf("%s_match_hold", tag), match1, 1);
   endtask

   initial begin
      logic [2:0] s;
      logic [7:0] exp_y;
      bit         en;
      int         d1, d2, b1, b2;

      rst_n = 1'b0; g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
      mode = 1'b0; start = 1'b0; sel_in = 3'd0;
      #12;
      chk("rst_y", y_n1, 8'hFF);
      chk("rst_f", f_out1, 0);
      chk("rst_sel", cur_sel1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_tt", tt1, 0);
      chk("rst_match", match1, 0);
      tick();
      rst_n = 1'b1;

      // directed direct-mode decode
      sel_in = 3'd5; tick();
      chk("dir5_y", y_n1, 8'hDF);
      chk("dir5_f", f_out1, 1);
      chk("dir5_sel", cur_sel1, 5);
      sel_in = 3'd3; tick();
      chk("dir3_y", y_n1, 8'hF7);
      chk("dir3_f", f_out1, 0);

      // enable gating
      sel_in = 3'd2; g2a_n = 1'b1; tick();
      chk("g2a_y", y_n1, 8'hFF);
      chk("g2a_f", f_out1, 0);
      g2a_n = 1'b0; g1 = 1'b0; tick();
      chk("g1_y", y_n1, 8'hFF);
      chk("g1_f", f_out1, 0);
      g1 = 1'b1; g2b_n = 1'b1; tick();
      chk("g2b_y", y_n1, 8'hFF);
      chk("g2b_f", f_out1, 0);
      g2b_n = 1'b0;

      // random direct decode, start pulses with mode=0 must be ignored
      for (int i = 0; i < 40; i++) begin
         s      = 3'($urandom_range(7));
         g1     = ($urandom_range(4) != 0);
         g2a_n  = ($urandom_range(4) == 0);
         g2b_n  = ($urandom_range(4) == 0);
         start  = ($urandom_range(3) == 0);
         sel_in = s;
         tick();
         en    = g1 && !g2a_n && !g2b_n;
         exp_y = en ? ~(8'd1 << s) : 8'hFF;
         chk($sformatf("rnd%0d_y1", i), y_n1, exp_y);
         chk($sformatf("rnd%0d_f1", i), f_out1, en && m1[s]);
         chk($sformatf("rnd%0d_sel1", i), cur_sel1, s);
         chk($sformatf("rnd%0d_busy1", i), busy1, 0);
         chk($sformatf("rnd%0d_y2", i), y_n2, exp_y);
         chk($sformatf("rnd%0d_f2", i), f_out2, en && m2[s]);
      end
      start = 1'b0;

      // full scan, paused scan, randomly paused scan
      scan_dut1("scan", 0, 0, 1'b0);
      scan_dut1("pause", 4, 3, 1'b0);
      scan_dut1("rpause", 0, 0, 1'b1);

      // reset in the middle of a scan
      g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
      mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("mid_sel", cur_sel1, 6);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_y", y_n1, 8'hFF);
      chk("mid_rst_busy", busy1, 0);
      chk("mid_rst_tt", tt1, 0);
      chk("mid_rst_sel", cur_sel1, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("post_rst_done_c%0d", i), done1, 0);
         chk($sformatf("post_rst_busy_c%0d", i), busy1, 0);
      end

      // both instances: STEP_DIV=2 timing, start ignored while busy
      mode = 1'b1; start = 1'b1; tick();
      d1 = 0; d2 = 0; b1 = 0; b2 = 0;
      for (int c = 1; c <= 40; c++) begin
         start = (c == 3);
         if (c == 5) chk("busy_start_ignored_sel", cur_sel1, 4);
         b1 += int'(busy1);
         b2 += int'(busy2);
         if (done1 && d1 == 0) d1 = c;
         if (done2 && d2 == 0) d2 = c;
         tick();
      end
      start = 1'b0;
      chk("d1_done_cycle", d1, 9);
      chk("d1_busy_cycles", b1, 8);
      chk("d2_done_cycle", d2, 17);
      chk("d2_busy_cycles", b2, 16);
      chk("d1_tt", tt1, m1);
      chk("d1_match", match1, 1);
      chk("d2_tt", tt2, m2);
      chk("d2_match", match2, 1);
`ifdef SCAN_MISMATCH_CNT_EN
      chk("d2_mm", mm2, 0);
`endif

      // rescan after done clears then rebuilds the table
      start = 1'b1; tick(); start = 1'b0;
      chk("rescan_tt_clr", tt1, 0);
      chk("rescan_match_clr", match1, 0);
      chk("rescan_busy", busy1, 1);
      for (int i = 0; i < 8; i++) tick();
      chk("rescan_done", done1, 1);
      chk("rescan_tt", tt1, m1);
      chk("rescan_match", match1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decoder_minterm_scanner.md
Name: decoder_minterm_scanner

Overview:
Parametrised, registered active-low N-to-2^N decoder with 74LS138-style enables (G1, G2A_n, G2B_n) and a programmable sum-of-minterms output. It supports two modes:
- Direct mode: decodes a live select input.
- Scan mode: sweeps all 2^N select codes automatically, captures the resulting truth table and flags a match against the expected minterm mask.

The block is the self-checking successor of the fixed 3-to-8 decoder plus minterm-OR lab function.

Parameters:
SEL_W, 3, select width N; decoder has 2^N outputs (legal 1..6)
MINTERMS, 8'b1010_0101, expected function mask, width 2^SEL_W; bit k set = minterm k in sum (default = sum(0,2,5,7))
STEP_DIV, 1, clock cycles per scan step (legal >=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
g1  in  1  active-high enable
g2a_n  in  1  active-low enable
g2b_n  in  1  active-low enable
mode  in  1  0 = direct, 1 = scan (sampled only in IDLE)
sel_in  in  SEL_W  select code, direct mode
start  in  1  single-cycle scan request
y_n  out  2^SEL_W  registered decoder outputs, active low
f_out  out  1  registered sum-of-minterms of current decoded code
cur_sel  out  SEL_W  code currently driving y_n
busy  out  1  high in SCAN state
done  out  1  one-cycle pulse at scan completion
tt  out  2^SEL_W  captured truth table, bit k = f for code k
match  out  1  tt == MINTERMS, valid from done until next start

Behaviour:
- Enabled = g1 & ~g2a_n & ~g2b_n.
- Reset (asynchronous, any state including mid-scan): y_n all ones, f_out 0, cur_sel 0, busy 0, done 0, tt 0, match 0, state IDLE, step counter 0.
- Decode: when enabled, y_n bit cur_sel low, all others high. When disabled, y_n all ones and f_out 0.
- f_out = OR over k of (~y_n[k] & MINTERMS[k]), computed from the next-state value so f_out aligns with y_n in the same cycle.
- State IDLE, mode=0 (direct):
  - Each cycle, cur_sel <= sel_in; y_n and f_out update accordingly.
  - Latency: 1 clock from sel_in/enables to y_n/f_out.
- IDLE -> SCAN: when start=1 and mode=1.
  - On entry: cur_sel <= 0, tt <= 0, match <= 0, step counter <= 0, busy <= 1.
- SCAN:
  - Each step holds cur_sel for STEP_DIV enabled cycles.
  - On the last cycle of a step: tt[cur_sel] <= f_out, then cur_sel increments.
  - Enables deasserted mid-scan pause the scan: step counter and cur_sel hold, y_n all ones, no tt capture. The scan resumes when enables return.
  - start, mode and sel_in are ignored while busy.
- SCAN -> DONE: after capture at cur_sel = 2^SEL_W-1.
  - cur_sel wraps to 0 on this transition; it does not overflow.
- DONE: lasts one cycle.
  - done=1, busy=0, match <= (tt == MINTERMS), using the final tt including the last capture.
  - Next state is IDLE.
  - tt and match hold until the next scan start or reset.
- Scan length with enables held: 2^SEL_W*STEP_DIV cycles in SCAN plus 1 in DONE.
  - SEL_W=3, STEP_DIV=1: busy high 8 cycles, done on the 9th cycle after the start edge.
- start coincident with mode=0: ignored; direct operation continues.

Optional Feature:
Macro SCAN_MISMATCH_CNT_EN.
- Defined:
  - Extra output mismatch_cnt, SEL_W+1 bits.
  - Cleared on reset and on scan start.
  - Incremented on each capture where the captured bit != MINTERMS[cur_sel].
  - Saturates at 2^SEL_W.
  - Value is final at done and holds afterwards.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
1. Direct decode: mode=0, enables active, sel_in=5 -> next cycle y_n=8'b1101_1111, f_out=1, cur_sel=5. sel_in=3 -> y_n=8'b1111_0111, f_out=0.
2. Enable gating: g2a_n=1, sel_in=2 -> y_n=8'hFF, f_out=0. Same result for g1=0 and for g2b_n=1.
3. Full scan: mode=1, start pulse, default MINTERMS -> busy 8 cycles, cur_sel 0..7, done pulse, tt=8'hA5, match=1 (mismatch_cnt=0 if enabled).
4. Scan pause: drop g1 for 3 cycles at cur_sel=4 -> cur_sel holds 4, y_n=8'hFF, done arrives 3 cycles later than in test 3, tt=8'hA5.
5. Reset mid-scan: rst_n low at cur_sel=6 -> immediately y_n=8'hFF, busy=0, tt=0. After release: IDLE, no done pulse.
6. Mismatch and STEP_DIV: MINTERMS=8'hA4, STEP_DIV=2 -> busy 16 cycles, tt=8'hA4, match=1. Force tt-expected mismatch via alternate MINTERMS instance 8'hA5 vs driven code skip? No: instance with mask 8'hA5, check start during busy is ignored and second start after done rescans with identical tt=8'hA5.
